// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - 4-digit common-anode seven-segment scan driver with frame snapshot and leading-zero blanking
module fnd_scan_driver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int LZ_BLANK = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_1000_value,
    input  logic [3:0] i_100_value,
    input  logic [3:0] i_10_value,
    input  logic [3:0] i_1_value,
    output logic [3:0] o_fndSelect,
    output logic [7:0] o_fndFont
);

    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam bit LZ_EN = (LZ_BLANK != 0);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("fnd_scan_driver: CLK_FREQ/SCAN_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_D0 = 2'd0,
        S_D1 = 2'd1,
        S_D2 = 2'd2,
        S_D3 = 2'd3
    } scan_state_t;

    scan_state_t r_state;
    scan_state_t w_next_state;

    logic [CW-1:0] r_div_cnt;
    logic          w_tick;
    logic [3:0]    r_thou;
    logic [3:0]    r_hund;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          w_blank3;
    logic          w_blank2;
    logic          w_blank1;
    logic [3:0]    w_sel_next;
    logic [7:0]    w_font_next;

    function automatic logic [7:0] f_seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign w_tick = (r_div_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_D3;
        end else if (w_tick) begin
            r_state <= w_next_state;
        end
    end

    // Blanking is judged on the frame snapshot so a whole frame is consistent.
    assign w_blank3 = LZ_EN && (r_thou == 4'd0);
    assign w_blank2 = w_blank3 && (r_hund == 4'd0);
    assign w_blank1 = w_blank2 && (r_tens == 4'd0);

    always_comb begin
        w_next_state = r_state;
        w_sel_next   = 4'b1111;
        w_font_next  = 8'hFF;
        case (r_state)
            S_D3: w_next_state = S_D0;
            S_D0: w_next_state = S_D1;
            S_D1: w_next_state = S_D2;
            S_D2: w_next_state = S_D3;
            default: w_next_state = S_D3;
        endcase
        case (w_next_state)
            S_D0: begin
                // Frame start: the ones digit comes from the live input being snapshotted now.
                w_sel_next  = 4'b1110;
                w_font_next = f_seg7(i_1_value);
            end
            S_D1: begin
                w_sel_next  = 4'b1101;
                w_font_next = w_blank1 ? 8'hFF : f_seg7(r_tens);
            end
            S_D2: begin
                w_sel_next  = 4'b1011;
                w_font_next = w_blank2 ? 8'hFF : f_seg7(r_hund);
            end
            default: begin
                w_sel_next  = 4'b0111;
                w_font_next = w_blank3 ? 8'hFF : f_seg7(r_thou);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_thou <= 4'd0;
            r_hund <= 4'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (w_tick && (r_state == S_D3)) begin
            r_thou <= i_1000_value;
            r_hund <= i_100_value;
            r_tens <= i_10_value;
            r_ones <= i_1_value;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fndSelect <= 4'b1111;
            o_fndFont   <= 8'hFF;
        end else if (w_tick) begin
            o_fndSelect <= w_sel_next;
            o_fndFont   <= w_font_next;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb/tb_fnd_scan_driver.sv - self-checking bench for fnd_scan_driver with DIV=4, both blanking modes
module tb_fnd_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din [4];
    logic [3:0] sel_lz, sel_nz;
    logic [7:0] font_lz, font_nz;

    int checks = 0;
    int errors = 0;

    int         edges;
    int         pos;
    logic [3:0] snap [4];
    logic [3:0] exp_sel;
    logic [7:0] exp_font_lz;
    logic [7:0] exp_font_nz;

    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    fnd_scan_driver #(.CLK_FREQ(40), .SCAN_HZ(10), .LZ_BLANK(1)) u_dut_lz (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_1000_value (din[3]),
        .i_100_value  (din[2]),
        .i_10_value   (din[1]),
        .i_1_value    (din[0]),
        .o_fndSelect  (sel_lz),
        .o_fndFont    (font_lz)
    );

    fnd_scan_driver #(.CLK_FREQ(40), .SCAN_HZ(10), .LZ_BLANK(0)) u_dut_nz (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_1000_value (din[3]),
        .i_100_value  (din[2]),
        .i_10_value   (din[1]),
        .i_1_value    (din[0]),
        .o_fndSelect  (sel_nz),
        .o_fndFont    (font_nz)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edges       = 0;
        pos         = -1;
        exp_sel     = 4'b1111;
        exp_font_lz = 8'hFF;
        exp_font_nz = 8'hFF;
        for (int j = 0; j < 4; j++) snap[j] = 4'd0;
    endtask

    // Every 4th edge after release shows the next digit position 0,1,2,3,0...
    task automatic model_edge();
        bit blank;
        if (!rst_n) begin
            model_reset();
        end else begin
            edges++;
            if (edges % 4 == 0) begin
                pos = ((edges / 4) - 1) % 4;
                if (pos == 0) for (int j = 0; j < 4; j++) snap[j] = din[j];
                exp_sel     = ~(4'b0001 << pos);
                exp_font_nz = SEG[snap[pos]];
                blank = (pos > 0);
                for (int j = pos; j < 4; j++) if (snap[j] != 4'd0) blank = 1'b0;
                exp_font_lz = blank ? 8'hFF : SEG[snap[pos]];
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sel_lz"},  {4'b0, sel_lz},  {4'b0, exp_sel});
        chk({tag, "_font_lz"}, font_lz,         exp_font_lz);
        chk({tag, "_sel_nz"},  {4'b0, sel_nz},  {4'b0, exp_sel});
        chk({tag, "_font_nz"}, font_nz,         exp_font_nz);
    endtask

    task automatic step(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic set_din(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te, input logic [3:0] on);
        din[3] = th; din[2] = hu; din[1] = te; din[0] = on;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        set_din(4'd0, 4'd0, 4'd0, 4'd3);
        model_reset();
        step(5, "reset");

        rst_n = 1'b1;
        step(3, "pre_tick");
        step(1, "first_tick");
        chk("first_font_b0", font_lz, 8'hB0);
        chk("first_sel_1110", {4'b0, sel_lz}, 8'h0E);
        step(15, "lz_0003");

        set_din(4'd1, 4'd2, 4'd3, 4'd4);
        step(20, "order_1234");
        for (int k = 0; k < 16 && pos != 1; k++) step(1, "seek_idx1");
        chk("reach_idx1", {7'b0, pos == 1}, 8'd1);
        set_din(4'd9, 4'd9, 4'd9, 4'd9);
        step(8, "snapshot_old");
        chk("snap_thou_old", font_nz, 8'hF9);
        step(16, "snapshot_new");

        set_din(4'd0, 4'd0, 4'd0, 4'd2);
        step(20, "lz_0002");
        set_din(4'd0, 4'd1, 4'd0, 4'd0);
        step(20, "lz_0100");
        set_din(4'd0, 4'd0, 4'd0, 4'd0);
        step(20, "lz_0000");
        set_din(4'hA, 4'hB, 4'hE, 4'hF);
        step(20, "hex_abef");
        chk("hex_thou_88", font_nz, 8'h88);

        for (int k = 0; k < 16 && pos != 2; k++) step(1, "seek_idx2");
        step(1, "mid_idx2");
        async_reset("async_mid");
        step(3, "async_hold");
        set_din(4'd0, 4'd0, 4'd0, 4'd3);
        rst_n = 1'b1;
        step(3, "restart_idle");
        step(1, "restart_tick");
        chk("restart_font_b0", font_lz, 8'hB0);

        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int j = 0; j < 4; j++)
                    din[j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 150) == 0) begin
                async_reset("rand_async");
                step($urandom_range(1, 3), "rand_hold");
                rst_n = 1'b1;
            end
            step(1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
